// File: rtl/interrupt_request_8259a.sv
// interrupt_request_8259a: 8259A IRR stage, level/edge sampling of IR7..IR0 with freeze and per-bit clear
module interrupt_request_8259a (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       level_or_edge_triggered_config,
    input  logic       freeze,
    input  logic [7:0] clear_interrupt_request,
    input  logic [7:0] interrupt_request_pin,
    output logic [7:0] interrupt_request_register
);
    logic [7:0] r_low_input_latch;
    logic [7:0] r_irr;
    logic [7:0] w_edge;
    logic [7:0] w_next_latch;
    logic [7:0] w_next_irr;
    // Arm on any sampled low, disarm on clear; IRR follows pin or armed edge unless frozen, clear always wins
    always_comb begin
        w_edge       = r_low_input_latch & interrupt_request_pin;
        w_next_latch = (r_low_input_latch | ~interrupt_request_pin) & ~clear_interrupt_request;
        w_next_irr   = ~clear_interrupt_request &
                       (freeze ? r_irr : (level_or_edge_triggered_config ? interrupt_request_pin : w_edge));
    end
    // State registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_low_input_latch <= 8'h00;
            r_irr             <= 8'h00;
        end else begin
            r_low_input_latch <= w_next_latch;
            r_irr             <= w_next_irr;
        end
    end
    assign interrupt_request_register = r_irr;
endmodule

// File: tb/tb_interrupt_request_8259a.sv
// tb_interrupt_request_8259a: directed and randomized checks of the IRR stage against a per-line behavioural model
module tb_interrupt_request_8259a;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       level_or_edge_triggered_config = 1'b0;
    logic       freeze = 1'b0;
    logic [7:0] clear_interrupt_request = 8'h00;
    logic [7:0] interrupt_request_pin = 8'h00;
    logic [7:0] interrupt_request_register;

    int checks = 0;
    int errors = 0;

    // Model: per IR line, whether a low has been seen since the last clear/reset, and whether a request is pending
    bit m_seen_low [8];
    bit m_pending  [8];

    interrupt_request_8259a dut (
        .clock                          (clock),
        .reset_n                        (reset_n),
        .level_or_edge_triggered_config (level_or_edge_triggered_config),
        .freeze                         (freeze),
        .clear_interrupt_request        (clear_interrupt_request),
        .interrupt_request_pin          (interrupt_request_pin),
        .interrupt_request_register     (interrupt_request_register)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] model_vec();
        logic [7:0] v;
        for (int n = 0; n < 8; n++) v[n] = m_pending[n];
        return v;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 8; n++) begin
            m_seen_low[n] = 0;
            m_pending[n]  = 0;
        end
    endtask

    // One clock: inputs are stable before the edge; model advances with those inputs; sample 1 ns after
    task automatic cycle();
        logic       lvl, frz;
        logic [7:0] clr, pin;
        lvl = level_or_edge_triggered_config;
        frz = freeze;
        clr = clear_interrupt_request;
        pin = interrupt_request_pin;
        @(posedge clock);
        for (int n = 0; n < 8; n++) begin
            if (clr[n]) begin
                m_pending[n]  = 0;
                m_seen_low[n] = 0;
            end else begin
                if (!frz) m_pending[n] = lvl ? pin[n] : (m_seen_low[n] && pin[n]);
                if (!pin[n]) m_seen_low[n] = 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #2 reset_n = 1'b1;
        level_or_edge_triggered_config = 1'b1;
        interrupt_request_pin = 8'hFF;
        cycle();
        checks++;
        if (interrupt_request_register !== 8'hFF) begin
            errors++;
            $display("FAIL reset_pre_level got=%h exp=%h", interrupt_request_register, 8'hFF);
        end
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (interrupt_request_register !== 8'h00) begin
            errors++;
            $display("FAIL reset_async got=%h exp=%h", interrupt_request_register, 8'h00);
        end
        #1 reset_n = 1'b1;
        level_or_edge_triggered_config = 1'b0;
        cycle();
        cycle();
        checks++;
        if (interrupt_request_register !== 8'h00) begin
            errors++;
            $display("FAIL reset_edge_high_pin got=%h exp=%h", interrupt_request_register, 8'h00);
        end
    endtask

    task automatic test_level();
        level_or_edge_triggered_config = 1'b1;
        interrupt_request_pin = 8'h01;
        cycle();
        checks++;
        if (interrupt_request_register !== 8'h01) begin
            errors++;
            $display("FAIL level_set got=%h exp=%h", interrupt_request_register, 8'h01);
        end
        clear_interrupt_request = 8'h01;
        cycle();
        checks++;
        if (interrupt_request_register !== 8'h00) begin
            errors++;
            $display("FAIL level_clear got=%h exp=%h", interrupt_request_register, 8'h00);
        end
        clear_interrupt_request = 8'h00;
        cycle();
        checks++;
        if (interrupt_request_register !== 8'h01) begin
            errors++;
            $display("FAIL level_reassert got=%h exp=%h", interrupt_request_register, 8'h01);
        end
        interrupt_request_pin = 8'h00;
        cycle();
        checks++;
        if (interrupt_request_register !== 8'h00) begin
            errors++;
            $display("FAIL level_drop got=%h exp=%h", interrupt_request_register, 8'h00);
        end
    endtask

    task automatic test_edge_walk();
        logic [7:0] v;
        level_or_edge_triggered_config = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            v = 8'h01 << i;
            interrupt_request_pin = 8'h00;
            cycle();
            checks++;
            if (interrupt_request_register !== 8'h00) begin
                errors++;
                $display("FAIL edge_walk_low bit=%0d got=%h exp=%h", i, interrupt_request_register, 8'h00);
            end
            interrupt_request_pin = v;
            cycle();
            checks++;
            if (interrupt_request_register !== v) begin
                errors++;
                $display("FAIL edge_walk_high bit=%0d got=%h exp=%h", i, interrupt_request_register, v);
            end
        end
    endtask

    task automatic test_edge_clear_rearm();
        clear_interrupt_request = 8'hFF;
        cycle();
        checks++;
        if (interrupt_request_register !== 8'h00) begin
            errors++;
            $display("FAIL edge_clear got=%h exp=%h", interrupt_request_register, 8'h00);
        end
        clear_interrupt_request = 8'h00;
        cycle();
        cycle();
        checks++;
        if (interrupt_request_register !== 8'h00) begin
            errors++;
            $display("FAIL edge_no_rerequest got=%h exp=%h", interrupt_request_register, 8'h00);
        end
        interrupt_request_pin = 8'h00;
        cycle();
        interrupt_request_pin = 8'h01;
        cycle();
        checks++;
        if (interrupt_request_register !== 8'h01) begin
            errors++;
            $display("FAIL edge_rearm got=%h exp=%h", interrupt_request_register, 8'h01);
        end
    endtask

    task automatic test_freeze();
        level_or_edge_triggered_config = 1'b1;
        interrupt_request_pin = 8'h10;
        cycle();
        checks++;
        if (interrupt_request_register !== 8'h10) begin
            errors++;
            $display("FAIL freeze_setup got=%h exp=%h", interrupt_request_register, 8'h10);
        end
        freeze = 1'b1;
        interrupt_request_pin = 8'h20;
        cycle();
        checks++;
        if (interrupt_request_register !== 8'h10) begin
            errors++;
            $display("FAIL freeze_hold got=%h exp=%h", interrupt_request_register, 8'h10);
        end
        clear_interrupt_request = 8'h10;
        cycle();
        checks++;
        if (interrupt_request_register !== 8'h00) begin
            errors++;
            $display("FAIL freeze_clear got=%h exp=%h", interrupt_request_register, 8'h00);
        end
        clear_interrupt_request = 8'h00;
        freeze = 1'b0;
        cycle();
        checks++;
        if (interrupt_request_register !== 8'h20) begin
            errors++;
            $display("FAIL freeze_release got=%h exp=%h", interrupt_request_register, 8'h20);
        end
    endtask

    task automatic test_simultaneous();
        level_or_edge_triggered_config = 1'b0;
        interrupt_request_pin = 8'h00;
        cycle();
        interrupt_request_pin = 8'h08;
        clear_interrupt_request = 8'h08;
        cycle();
        checks++;
        if (interrupt_request_register !== 8'h00) begin
            errors++;
            $display("FAIL simul_clear_wins got=%h exp=%h", interrupt_request_register, 8'h00);
        end
        clear_interrupt_request = 8'h00;
        cycle();
        checks++;
        if (interrupt_request_register !== 8'h00) begin
            errors++;
            $display("FAIL simul_disarmed got=%h exp=%h", interrupt_request_register, 8'h00);
        end
        interrupt_request_pin = 8'h00;
        cycle();
        interrupt_request_pin = 8'h08;
        cycle();
        checks++;
        if (interrupt_request_register !== 8'h08) begin
            errors++;
            $display("FAIL simul_new_edge got=%h exp=%h", interrupt_request_register, 8'h08);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp;
        for (int k = 0; k < 400; k++) begin
            interrupt_request_pin = 8'($urandom);
            clear_interrupt_request = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            freeze = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 15) == 0) level_or_edge_triggered_config = ~level_or_edge_triggered_config;
            cycle();
            exp = model_vec();
            checks++;
            if (interrupt_request_register !== exp) begin
                errors++;
                $display("FAIL random k=%0d got=%h exp=%h", k, interrupt_request_register, exp);
            end
        end
        freeze = 1'b0;
        clear_interrupt_request = 8'h00;
    endtask

    initial begin
        test_reset();
        test_level();
        test_edge_walk();
        test_edge_clear_rearm();
        test_freeze();
        test_simultaneous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
